// File: rtl/universal_shift_register_if.sv
// Bus bundle for the universal shift register.
// The master drives the controls; the slave returns register state.
interface universal_shift_register_if #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
);
  logic             L;
  logic [WIDTH-1:0] D;
  logic             S;
  logic [2:0]       M;
  logic [CW-1:0]    N;
  logic             SL;
  logic             SR;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] nQ;
  logic             SOL;
  logic             SOR;
  logic             B;
  logic             DN;

  modport master (
    output L, D, S, M, N, SL, SR,
    input  Q, nQ, SOL, SOR, B, DN
  );

  modport slave (
    input  L, D, S, M, N, SL, SR,
    output Q, nQ, SOL, SOR, B, DN
  );
endinterface

// File: rtl/universal_shift_register.sv
// Universal shift register with parallel load and counted
// shift/rotate operations, busy flag and one-cycle done pulse.
module universal_shift_register #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic                           C,
  input  logic                           nR,
  universal_shift_register_if.slave      bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] M_SHL = 3'b001;
  localparam logic [2:0] M_SHR = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;
  localparam logic [2:0] M_ASR = 3'b101;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dn_q, dn_d;
  logic [WIDTH-1:0] step;

  // One step of the latched mode; SL/SR are taken live.
  always_comb begin
    step = q_q;
    unique case (mode_q)
      M_SHL:   step = {q_q[WIDTH-2:0], bus.SL};
      M_SHR:   step = {bus.SR, q_q[WIDTH-1:1]};
      M_ROL:   step = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      M_ROR:   step = {q_q[0], q_q[WIDTH-1:1]};
      M_ASR:   step = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
      default: step = q_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    q_d     = q_q;
    dn_d    = 1'b0;
    unique case (1'b1)
      (state_q == RUN): begin
        q_d   = step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
          state_d = IDLE;
          dn_d    = 1'b1;
        end
      end
      default: begin
        if (bus.L) begin
          q_d = bus.D;
        end else if (bus.S) begin
          if (bus.N == '0) begin
            dn_d = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = bus.N;
            mode_d  = bus.M;
          end
        end
      end
    endcase
  end

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      q_q     <= '0;
      dn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      dn_q    <= dn_d;
    end
  end

  assign bus.Q   = q_q;
  assign bus.nQ  = ~q_q;
  assign bus.SOL = q_q[WIDTH-1];
  assign bus.SOR = q_q[0];
  assign bus.B   = (state_q == RUN);
  assign bus.DN  = dn_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomized bench with a behavioural reference model plus
// directed literal scenarios for the universal shift register.
module tb_universal_shift_register;

  localparam int W    = 4;
  localparam int CWD  = 3;
  localparam int MASK = (1 << W) - 1;

  logic C;
  logic nR;

  universal_shift_register_if #(.WIDTH(W), .CW(CWD)) u ();

  universal_shift_register #(.WIDTH(W), .CW(CWD)) dut (
    .C   (C),
    .nR  (nR),
    .bus (u)
  );

  int errors = 0;
  int checks = 0;

  int mq    = 0;
  int mbusy = 0;
  int mrem  = 0;
  int mmode = 0;
  int mdn   = 0;

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp,
               $time);
    end
  endtask

  function automatic int step_of(input int q, input int m,
                                 input int sl, input int sr);
    case (m)
      1: return ((q * 2) + sl) & MASK;
      2: return (q / 2) + sr * (1 << (W - 1));
      3: return ((q * 2) & MASK) + (q / (1 << (W - 1)));
      4: return (q / 2) + (q % 2) * (1 << (W - 1));
      5: return (q / 2) + (q & (1 << (W - 1)));
      default: return q;
    endcase
  endfunction

  // Reference model: counted operation described by remaining steps
  always @(posedge C or negedge nR) begin
    if (!nR) begin
      mq = 0; mbusy = 0; mrem = 0; mdn = 0;
    end else begin
      mdn = 0;
      if (mbusy != 0) begin
        mq   = step_of(mq, mmode, int'(u.SL), int'(u.SR));
        mrem = mrem - 1;
        if (mrem == 0) begin
          mbusy = 0;
          mdn   = 1;
        end
      end else if (u.L) begin
        mq = int'(u.D);
      end else if (u.S) begin
        if (u.N == 0) mdn = 1;
        else begin
          mbusy = 1;
          mrem  = int'(u.N);
          mmode = int'(u.M);
        end
      end
    end
  end

  always @(negedge C) begin
    chk("model_Q",   32'(u.Q),   32'(mq));
    chk("model_nQ",  32'(u.nQ),  32'((~mq) & MASK));
    chk("model_SOL", 32'(u.SOL), 32'((mq >> (W - 1)) & 1));
    chk("model_SOR", 32'(u.SOR), 32'(mq & 1));
    chk("model_B",   32'(u.B),   32'(mbusy));
    chk("model_DN",  32'(u.DN),  32'(mdn));
  end

  task automatic cyc();
    @(negedge C);
    #1;
  endtask

  task automatic idle_in();
    u.L = 0; u.S = 0; u.M = 0; u.N = 0; u.D = 0;
  endtask

  task automatic load(input logic [3:0] v);
    u.L = 1; u.D = v; u.S = 0;
    cyc();
    u.L = 0;
  endtask

  logic [3:0] rot_exp [5];

  initial begin
    nR = 0;
    u.SL = 0; u.SR = 0;
    idle_in();
    cyc(); cyc();
    chk("rst_Q",  32'(u.Q),  32'h0);
    chk("rst_nQ", 32'(u.nQ), 32'hF);
    chk("rst_B",  32'(u.B),  32'h0);
    chk("rst_DN", 32'(u.DN), 32'h0);
    nR = 1;
    cyc();

    load(4'b1010);
    chk("load_Q", 32'(u.Q), 32'hA);
    #1 nR = 0;
    #1;
    chk("async_Q",  32'(u.Q),  32'h0);
    chk("async_nQ", 32'(u.nQ), 32'hF);
    chk("async_B",  32'(u.B),  32'h0);
    chk("async_DN", 32'(u.DN), 32'h0);
    cyc();
    nR = 1;
    cyc();

    load(4'b1011);
    chk("shl_load", 32'(u.Q), 32'hB);
    u.S = 1; u.M = 3'b001; u.N = 2; u.SL = 1;
    cyc();
    u.S = 0;
    chk("shl_k_Q", 32'(u.Q), 32'hB);
    chk("shl_k_B", 32'(u.B), 32'h1);
    cyc();
    chk("shl_1_Q",  32'(u.Q),  32'h7);
    chk("shl_1_DN", 32'(u.DN), 32'h0);
    cyc();
    chk("shl_2_Q",  32'(u.Q),  32'hF);
    chk("shl_2_B",  32'(u.B),  32'h0);
    chk("shl_2_DN", 32'(u.DN), 32'h1);
    cyc();
    chk("shl_after_DN", 32'(u.DN), 32'h0);

    rot_exp = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
    load(4'b1000);
    u.S = 1; u.M = 3'b100; u.N = 5;
    cyc();
    u.S = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("ror_Q", 32'(u.Q), 32'(rot_exp[i]));
      chk("ror_DN", 32'(u.DN), (i == 4) ? 32'h1 : 32'h0);
    end

    load(4'b1000);
    u.S = 1; u.M = 3'b101; u.N = 2;
    cyc();
    u.S = 0;
    cyc();
    chk("asr_1", 32'(u.Q), 32'hC);
    cyc();
    chk("asr_2", 32'(u.Q), 32'hE);

    u.L = 1; u.S = 1; u.D = 4'b0110; u.M = 3'b001; u.N = 3;
    cyc();
    u.L = 0; u.S = 0;
    chk("ls_Q", 32'(u.Q), 32'h6);
    chk("ls_B", 32'(u.B), 32'h0);

    u.S = 1; u.M = 3'b010; u.N = 3; u.SR = 0;
    cyc();
    u.S = 0; u.L = 1; u.D = 4'b1111;
    cyc(); cyc(); cyc();
    chk("runload_Q",  32'(u.Q),  32'h0);
    chk("runload_DN", 32'(u.DN), 32'h1);
    u.L = 0;
    cyc();

    load(4'b0101);
    u.S = 1; u.N = 0;
    cyc();
    u.S = 0;
    chk("zero_Q",  32'(u.Q),  32'h5);
    chk("zero_DN", 32'(u.DN), 32'h1);
    chk("zero_B",  32'(u.B),  32'h0);
    cyc();
    chk("zero_DN2", 32'(u.DN), 32'h0);

    u.S = 1; u.M = 3'b001; u.N = 6; u.SL = 1;
    cyc();
    u.S = 0;
    cyc(); cyc();
    chk("abort_pre", 32'(u.Q), 32'h7);
    #1 nR = 0;
    #1;
    chk("abort_Q",  32'(u.Q),  32'h0);
    chk("abort_B",  32'(u.B),  32'h0);
    chk("abort_DN", 32'(u.DN), 32'h0);
    cyc();
    nR = 1;
    cyc();
    chk("abort_DN2", 32'(u.DN), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      u.L  = ($urandom_range(0, 5) == 0);
      u.S  = ($urandom_range(0, 2) == 0);
      u.D  = 4'($urandom);
      u.M  = 3'($urandom);
      u.N  = 3'($urandom);
      u.SL = 1'($urandom);
      u.SR = 1'($urandom);
      nR   = ($urandom_range(0, 199) != 0);
      cyc();
    end
    nR = 1;
    idle_in();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: port C is the clock, port nR is the reset.
REQ-002 Parameter WIDTH, default 4, register width; legal values are WIDTH >= 2.
REQ-003 Parameter CW, default 3, step-count width.
REQ-004 C  in  1  clock; all state changes on the rising edge.
REQ-005 nR  in  1  asynchronous active-low reset.
REQ-006 L  in  1  parallel load request.
REQ-007 D  in  WIDTH  parallel load data.
REQ-008 S  in  1  start request for a counted operation.
REQ-009 M  in  3  mode: 000 hold, 001 shift left, 010 shift right, 011 rotate left, 100 rotate right, 101 arithmetic shift right; 110 and 111 SHALL act as hold.
REQ-010 N  in  CW  number of steps.
REQ-011 SL  in  1  serial input for shift left; enters bit 0.
REQ-012 SR  in  1  serial input for shift right; enters bit WIDTH-1.
REQ-013 Q  out  WIDTH  register contents.
REQ-014 nQ  out  WIDTH  bitwise inverse of Q (combinational).
REQ-015 SOL  out  1  Q[WIDTH-1] (combinational).
REQ-016 SOR  out  1  Q[0] (combinational).
REQ-017 B  out  1  busy flag.
REQ-018 DN  out  1  one-cycle done pulse.

Function
REQ-019 The block SHALL have two states, IDLE and RUN, plus a CW-bit remaining-step counter.
REQ-020 IDLE with L=1: Q <= D at the edge; S SHALL be ignored that edge (load wins); state stays IDLE.
REQ-021 IDLE with L=0, S=1, N>0 at edge k:
- latch M and N, go to RUN, B=1 after edge k;
- Q is unchanged at edge k.
REQ-022 IDLE with L=0, S=1, N=0 at edge k: Q unchanged, stay IDLE, DN=1 for the cycle after edge k, B stays 0.
REQ-023 In RUN, each edge SHALL perform exactly one step of the latched mode and decrement the counter; steps occur at edges k+1 .. k+N.
REQ-024 At the edge performing the last step: go to IDLE, B=0, DN=1 for exactly one cycle.
REQ-025 Step definitions:
- shift left: Q <= {Q[WIDTH-2:0], SL};
- shift right: Q <= {SR, Q[WIDTH-1:1]};
- rotate left/right: wrap the end bit;
- arithmetic shift right: replicate Q[WIDTH-1];
- hold: Q unchanged.
REQ-026 SL and SR SHALL be sampled live at each step edge, not latched at start.
REQ-027 In RUN, L, S, M and N SHALL be ignored; a new start is accepted no earlier than the first edge with B=0.
REQ-028 N greater than WIDTH is legal: rotates wrap modulo WIDTH; shifts continue filling.
REQ-029 DN SHALL be 0 in every cycle other than those in REQ-022 and REQ-024.

Reset
REQ-030 nR=0 SHALL immediately, without a clock edge, force Q=0, nQ=all ones, B=0, DN=0, counter=0, state IDLE.
REQ-031 Reset during RUN SHALL abort the operation with no DN pulse.
REQ-032 After nR rises, the first rising edge SHALL operate normally.

Verification (WIDTH=4, CW=3)
REQ-033 Async reset: Q=1010, drive nR=0 mid-cycle -> Q=0000, nQ=1111 before the next edge; B=0, DN=0.
REQ-034 Load then shift left: L=1, D=1011 -> Q=1011; then S=1, M=001, N=2, SL=1 -> Q=0111, then Q=1111; B=1 for 2 cycles; DN pulses once after the 2nd step.
REQ-035 Rotate wrap: Q=1000, S=1, M=100, N=5 -> Q=0100, 0010, 0001, 1000, 0100; final Q=0100, DN once.
REQ-036 Arithmetic shift right: Q=1000, M=101, N=2 -> Q=1100, then Q=1110.
REQ-037 Collisions:
- L=1, S=1 in IDLE, D=0110 -> Q=0110, B stays 0;
- L=1, D=1111 during RUN -> ignored, the shift sequence completes unaltered.
REQ-038 Zero count and abort:
- S=1, N=0 -> Q unchanged, DN=1 one cycle, B=0;
- start M=001, N=6, then nR=0 after 2 steps -> Q=0000, B=0, no DN.
